// File: rtl/clock_div_prog_if.sv
// Control and status bundle for clock_div_prog.
// master drives enable/load/divisor; slave drives div_clock/tick/count/pending.
interface clock_div_prog_if #(
  parameter int WIDTH = 17
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] divisor;
  logic             div_clock;
  logic             tick;
  logic [WIDTH-1:0] count;
  logic             pending;

  modport master (
    output enable, load, divisor,
    input  div_clock, tick, count, pending
  );

  modport slave (
    input  enable, load, divisor,
    output div_clock, tick, count, pending
  );
endinterface

// File: rtl/clock_div_prog.sv
// Runtime-programmable divide-by-N: registered tick, near-50% div_clock.
// Ports: clock, reset (async high), bus (enable/load/divisor in; div_clock/tick/count/pending out).
module clock_div_prog #(
  parameter int WIDTH       = 17,
  parameter int DEFAULT_DIV = 4
) (
  input  logic            clock,
  input  logic            reset,
  clock_div_prog_if.slave bus
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] pdiv_q, pdiv_d;
  logic             tick_q, tick_d;
  logic             dclk_q, dclk_d;
  logic             pend_q, pend_d;
  logic             halted;
  logic             wrap;
  logic             apply;

  always_comb begin
    halted = (n_q == '0);
    wrap   = !halted && (cnt_q == n_q - WIDTH'(1));
    // A load on the applying edge wins: old pending is
    // superseded and the new value waits for the next wrap.
    apply  = bus.enable && pend_q && !bus.load
           && (halted || wrap);
    n_d    = apply ? pdiv_q : n_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    dclk_d = dclk_q;
    if (bus.enable) begin
      unique case (1'b1)
        halted:  cnt_d = '0;
        wrap:    cnt_d = '0;
        default: cnt_d = cnt_q + WIDTH'(1);
      endcase
      tick_d = wrap;
      // High for the upper ceil(N/2) phases; N=0 forces low.
      dclk_d = (n_d != '0) && (cnt_d >= (n_d >> 1));
    end
    pend_d = bus.load ? 1'b1 : (apply ? 1'b0 : pend_q);
    pdiv_d = bus.load ? bus.divisor : pdiv_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      n_q    <= WIDTH'(DEFAULT_DIV);
      pdiv_q <= '0;
      tick_q <= 1'b0;
      dclk_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      n_q    <= n_d;
      pdiv_q <= pdiv_d;
      tick_q <= tick_d;
      dclk_q <= dclk_d;
      pend_q <= pend_d;
    end
  end

  assign bus.count     = cnt_q;
  assign bus.tick      = tick_q;
  assign bus.div_clock = dclk_q;
  assign bus.pending   = pend_q;
endmodule

// File: tb/tb_clock_div_prog.sv
// Bench for clock_div_prog: directed scenarios plus random
// enable/load traffic against a phase-based reference model.
module tb_clock_div_prog;
  localparam int W = 17;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic reset_s = 1'b1;

  always #5 clock = ~clock;

  clock_div_prog_if #(.WIDTH(W)) bus ();
  clock_div_prog_if #(.WIDTH(6)) sbus ();

  clock_div_prog #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  clock_div_prog #(.WIDTH(6), .DEFAULT_DIV(4)) dut_s (
    .clock(clock),
    .reset(reset_s),
    .bus  (sbus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: phase within the current period of length n.
  int m_n, m_ph, m_pv;
  bit m_pend, m_tick, m_dc;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 4; m_ph = 0; m_pv = 0;
    m_pend = 0; m_tick = 0; m_dc = 0;
  endtask

  task automatic model_step(bit en, bit ld, int dv);
    bit boundary;
    if (en) begin
      boundary = 0;
      m_tick = 0;
      if (m_n == 0) begin
        m_ph = 0;
        boundary = 1;
      end else begin
        m_ph = m_ph + 1;
        if (m_ph == m_n) begin
          m_ph = 0;
          m_tick = 1;
          boundary = 1;
        end
      end
      if (boundary && m_pend && !ld) begin
        m_n = m_pv;
        m_pend = 0;
      end
      m_dc = (m_n != 0) && (2 * m_ph >= 2 * (m_n / 2));
    end else begin
      m_tick = 0;
    end
    if (ld) begin
      m_pend = 1;
      m_pv = dv;
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".count"}, 32'(bus.count), m_ph);
    check({tag, ".tick"}, 32'(bus.tick), 32'(m_tick));
    check({tag, ".div_clock"}, 32'(bus.div_clock), 32'(m_dc));
    check({tag, ".pending"}, 32'(bus.pending), 32'(m_pend));
  endtask

  task automatic cyc(string tag);
    @(posedge clock);
    model_step(bus.enable, bus.load, int'(bus.divisor));
    #1;
    check_all(tag);
  endtask

  initial begin
    int guard;
    bus.enable   = 1'b1;
    bus.load     = 1'b0;
    bus.divisor  = '0;
    sbus.enable  = 1'b1;
    sbus.load    = 1'b0;
    sbus.divisor = '0;
    model_reset();

    // Reset state
    @(negedge clock);
    check_all("reset");
    reset = 1'b0;

    // 1: default divide by 4
    for (int i = 1; i <= 8; i++) begin
      cyc("t1");
      if (i == 1) check("t1_no_tick_first", 32'(bus.tick), 0);
      if (i == 4) check("t1_first_tick", 32'(bus.tick), 1);
    end

    // 2: load 5 at count 1
    cyc("t2");
    bus.load = 1'b1;
    bus.divisor = W'(5);
    cyc("t2");
    bus.load = 1'b0;
    check("t2_pending", 32'(bus.pending), 1);
    repeat (14) cyc("t2");

    // 3: N=1, then halt, then resume with 3
    bus.load = 1'b1;
    bus.divisor = W'(1);
    cyc("t3");
    bus.load = 1'b0;
    repeat (8) cyc("t3");
    check("t3_n1_tick", 32'(bus.tick), 1);
    check("t3_n1_dclk", 32'(bus.div_clock), 1);
    bus.load = 1'b1;
    bus.divisor = W'(0);
    cyc("t3");
    bus.load = 1'b0;
    repeat (4) cyc("t3");
    check("t3_halt_count", 32'(bus.count), 0);
    check("t3_halt_tick", 32'(bus.tick), 0);
    check("t3_halt_dclk", 32'(bus.div_clock), 0);
    bus.load = 1'b1;
    bus.divisor = W'(3);
    cyc("t3");
    bus.load = 1'b0;
    cyc("t3");
    check("t3_resume_pending", 32'(bus.pending), 0);
    repeat (8) cyc("t3");

    // 4: enable low for 7 cycles at count 2
    guard = 0;
    while (m_ph != 2 && guard < 10) begin
      cyc("t4");
      guard++;
    end
    check("t4_sync", 32'(guard < 10), 1);
    bus.enable = 1'b0;
    repeat (7) cyc("t4");
    check("t4_hold_count", 32'(bus.count), 2);
    bus.enable = 1'b1;
    repeat (8) cyc("t4");

    // 5: async reset mid-period with pending set
    bus.load = 1'b1;
    bus.divisor = W'(7);
    cyc("t5");
    bus.load = 1'b0;
    cyc("t5");
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("t5_async");
    @(negedge clock);
    reset = 1'b0;
    repeat (10) cyc("t5");

    // 6: load max divisor on a wrap edge
    guard = 0;
    while (m_ph != 3 && guard < 10) begin
      cyc("t6");
      guard++;
    end
    check("t6_sync", 32'(guard < 10), 1);
    bus.load = 1'b1;
    bus.divisor = W'((1 << W) - 1);
    cyc("t6");
    bus.load = 1'b0;
    check("t6_wrap_tick", 32'(bus.tick), 1);
    check("t6_wrap_pending", 32'(bus.pending), 1);
    repeat (4) cyc("t6");
    check("t6_old_n_tick", 32'(bus.tick), 1);
    check("t6_applied", 32'(bus.pending), 0);
    repeat (300) cyc("t6");
    check("t6_count", 32'(bus.count), 300);

    // Random traffic
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 800; i++) begin
      bus.enable  = ($urandom_range(0, 9) != 0);
      bus.load    = ($urandom_range(0, 11) == 0);
      bus.divisor = W'($urandom_range(0, 9));
      cyc("rand");
    end
    bus.load = 1'b0;

    // Narrow instance: full period at N = 2^6-1
    @(negedge clock);
    reset_s = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    sbus.load = 1'b1;
    sbus.divisor = 6'd63;
    @(posedge clock);
    #1;
    sbus.load = 1'b0;
    check("w_wrap_tick", 32'(sbus.tick), 1);
    check("w_wrap_pending", 32'(sbus.pending), 1);
    repeat (4) @(posedge clock);
    #1;
    check("w_applied_tick", 32'(sbus.tick), 1);
    check("w_applied_pend", 32'(sbus.pending), 0);
    repeat (62) @(posedge clock);
    #1;
    check("w_top_count", 32'(sbus.count), 62);
    check("w_top_dclk", 32'(sbus.div_clock), 1);
    check("w_top_tick", 32'(sbus.tick), 0);
    @(posedge clock);
    #1;
    check("w_wrap_count", 32'(sbus.count), 0);
    check("w_wrap2_tick", 32'(sbus.tick), 1);
    check("w_wrap_dclk", 32'(sbus.div_clock), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
